tsm_product_sequencer: RTL and testbench
========================================

TSM_PRODUCT_SEQUENCER -- requirements
Module: tsm_product_sequencer

Interface
REQ-001 Parameter NSHARES, default 3: number of shares per variable, processed one share per accumulation step; legal range 2..8.
REQ-002 Parameter IDXW, default 2: width of share_idx, equal to clog2(NSHARES).
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port flush, input, 1: synchronous abort of the current operation.
REQ-006 Port share_in, input, 4: one share of {w,z,y,x} as bits [3:0].
REQ-007 Port share_valid, input, 1: share_in is valid.
REQ-008 Port share_ready, output, 1: the block accepts share_in this cycle.
REQ-009 Port share_idx, output, IDXW: index of the share expected next.
REQ-010 Port stage_acc, output, 15: registered partial-product vector, fed to the external combine stage.
REQ-011 Port stage_share, output, 4: equal to share_in, fed to the external combine stage.
REQ-012 Port stage_d, input, 15: combinational result of the combine stage.
REQ-013 Port out_valid, output, 1: result vector is valid.
REQ-014 Port out_ready, input, 1: the consumer accepts the result.
REQ-015 Port out_vec, output, 15: result vector.
REQ-016 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-017 The 15-bit vector order SHALL be: [0]x [1]y [2]z [3]w [4]xy [5]xz [6]xw [7]yz [8]yw [9]zw [10]xyz [11]xyw [12]xzw [13]yzw [14]xyzw.
REQ-018 The FSM SHALL have the states IDLE, ACCUM and DONE, with one state register.
REQ-019 Accepting a share SHALL mean share_valid & share_ready in the same cycle.
REQ-020 share_ready SHALL be high in IDLE and ACCUM, low in DONE, and low in any cycle where flush=1.
REQ-021 IDLE, on accept: acc <= load vector of share_in s, where bits [3:0] = s and each product bit = AND of its variables' bits of s; idx <= 1; go to ACCUM.
REQ-022 ACCUM, on accept: acc <= stage_d; idx <= idx+1.
REQ-023 ACCUM: when the accepted share has idx = NSHARES-1, go to DONE and set idx <= 0.
REQ-024 ACCUM without accept: acc and idx SHALL hold; a stall may last any number of cycles.
REQ-025 At most one share SHALL be absorbed per cycle; stage_d SHALL be sampled only in ACCUM accept cycles.
REQ-026 share_idx SHALL equal idx: 0 in IDLE, 1..NSHARES-1 in ACCUM, 0 in DONE.
REQ-027 DONE: out_valid=1 and out_vec=acc; both SHALL hold stable until out_ready=1.
REQ-028 DONE with out_ready=1: go to IDLE; the next share SHALL be accepted no earlier than the following cycle.
REQ-029 out_vec SHALL equal acc in all states; out_valid SHALL be low outside DONE.
REQ-030 stage_acc SHALL equal acc.
REQ-031 flush=1 in any state: next state IDLE, idx <= 0, acc <= 0, no accept. flush has priority over accept and over out_ready.
REQ-032 End-to-end latency from accepting share 0 to out_valid SHALL be NSHARES cycles with no stalls.
REQ-033 The block SHALL be glitch-free towards the combine stage: stage_acc comes only from the register; share_in is not combined with acc inside this block except through the REQ-021 load.

Reset
REQ-034 With rst_n=0, asynchronously: state=IDLE, idx=0, acc=15'h0000, out_valid=0, busy=0, share_idx=0; share_ready=1 once rst_n=1.
REQ-035 Reset deasserted mid-ACCUM or mid-DONE SHALL leave the block in IDLE; the partial result is discarded and no out_valid pulse follows.

Verification
REQ-036 Scenario: NSHARES=3, combine stage modelled per the masked-product equations, shares (x,y,z,w) shared as 0b1111, 0b0000, 0b0000 with no stalls -> out_valid in cycle 3 after the first accept, out_vec=15'h7FFF.
REQ-037 Scenario: share0=0b0101 accepted in IDLE -> next cycle stage_acc=15'h0025 (x, z and xz set), share_idx=1, busy=1.
REQ-038 Scenario: share_valid low for 5 cycles in ACCUM at idx=1 -> acc, share_idx and share_ready=1 stable; completion delayed by exactly 5 cycles.
REQ-039 Scenario: DONE with out_ready=0 for 4 cycles, then 1 -> out_vec constant, share_ready=0 throughout; IDLE one cycle after the handshake.
REQ-040 Scenario: flush=1 together with share_valid=1 at idx=2 -> no accept, next cycle IDLE with acc=0 and no out_valid.
REQ-041 Scenario: rst_n pulsed low mid-ACCUM -> outputs at reset values immediately (asynchronously), then a full operation completes correctly.

Source files
------------

// File: rtl/tsm_product_sequencer.sv
// Share-serial sequencer for a masked four-variable product vector: loads the
// first share, folds each further share in through an external combine stage.
module tsm_product_sequencer #(
  parameter int unsigned NSHARES = 3,
  parameter int unsigned IDXW    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [3:0]      share_in,
  input  logic            share_valid,
  output logic            share_ready,
  output logic [IDXW-1:0] share_idx,
  output logic [14:0]     stage_acc,
  output logic [3:0]      stage_share,
  input  logic [14:0]     stage_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [14:0]     out_vec,
  output logic            busy
);

  localparam int unsigned VW = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [VW-1:0]   acc_q, acc_d;
  logic            accept;
  logic            last_share;

  // Product vector of a single unshared value {w,z,y,x}.
  function automatic logic [VW-1:0] load_vec(input logic [3:0] s);
    logic [VW-1:0] v;
    v[0]  = s[0];
    v[1]  = s[1];
    v[2]  = s[2];
    v[3]  = s[3];
    v[4]  = s[0] & s[1];
    v[5]  = s[0] & s[2];
    v[6]  = s[0] & s[3];
    v[7]  = s[1] & s[2];
    v[8]  = s[1] & s[3];
    v[9]  = s[2] & s[3];
    v[10] = s[0] & s[1] & s[2];
    v[11] = s[0] & s[1] & s[3];
    v[12] = s[0] & s[2] & s[3];
    v[13] = s[1] & s[2] & s[3];
    v[14] = s[0] & s[1] & s[2] & s[3];
    return v;
  endfunction

  assign share_ready = ~flush & (state_q != DONE);
  assign accept      = share_valid & share_ready;
  assign last_share  = (idx_q == IDXW'(NSHARES - 1));

  // Combine stage sees only the register and the raw share.
  assign stage_acc   = acc_q;
  assign stage_share = share_in;
  assign out_vec     = acc_q;
  assign share_idx   = idx_q;
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (flush) begin
      state_d = IDLE;
      idx_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = load_vec(share_in);
            idx_d   = IDXW'(1);
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = stage_d;
            if (last_share) begin
              idx_d   = '0;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IDXW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          acc_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tsm_product_sequencer.sv
// Directed bench for tsm_product_sequencer with a bit-level model of the
// masked-product combine stage.
module tb_tsm_product_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  share_in;
  logic        share_valid;
  logic        share_ready;
  logic [1:0]  share_idx;
  logic [14:0] stage_acc;
  logic [3:0]  stage_share;
  logic [14:0] stage_d;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_vec;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tsm_product_sequencer #(.NSHARES(3), .IDXW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .share_in(share_in), .share_valid(share_valid), .share_ready(share_ready),
    .share_idx(share_idx), .stage_acc(stage_acc), .stage_share(stage_share),
    .stage_d(stage_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .busy(busy)
  );

  // Variable set of each vector bit, as a {w,z,y,x} mask.
  function automatic logic [3:0] mono(input int i);
    logic [3:0] m [15];
    m = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h9, 4'h6, 4'hA, 4'hC,
          4'h7, 4'hB, 4'hD, 4'hE, 4'hF};
    return m[i];
  endfunction

  function automatic logic acc_bit(input logic [14:0] a, input logic [3:0] t);
    for (int i = 0; i < 15; i++)
      if (mono(i) == t) return a[i];
    return 1'b1;
  endfunction

  // prod(V^s) over a variable set = XOR over subsets T of prod_T(V) * prod_rest(s).
  function automatic logic [14:0] combine(input logic [14:0] a, input logic [3:0] s);
    logic [14:0] r;
    logic [3:0]  m, rest, t4;
    r = '0;
    for (int i = 0; i < 15; i++) begin
      m = mono(i);
      for (int t = 0; t < 16; t++) begin
        t4 = 4'(t);
        if ((t4 & ~m) == 4'h0) begin
          rest = m & ~t4;
          r[i] = r[i] ^ ((t4 == 4'h0 ? 1'b1 : acc_bit(a, t4)) & ((s & rest) == rest));
        end
      end
    end
    return r;
  endfunction

  assign stage_d = combine(stage_acc, stage_share);

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full no-stall operation; out_valid must rise exactly after the third accept.
  task automatic run_op(input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [14:0] exp, input string tag);
    share_valid = 1'b1; share_in = s0;
    chk_eq({tag, "_rdy0"}, 32'(share_ready), 32'd1);
    cyc();
    chk_eq({tag, "_ov1"}, 32'(out_valid), 32'd0);
    share_in = s1;
    cyc();
    chk_eq({tag, "_idx2"}, 32'(share_idx), 32'd2);
    share_in = s2;
    cyc();
    share_valid = 1'b0;
    chk_eq({tag, "_ov3"}, 32'(out_valid), 32'd1);
    chk_eq({tag, "_vec"}, 32'(out_vec), 32'(exp));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; share_in = 4'h0; share_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_ov", 32'(out_valid), 32'd0);
    chk_eq("rst_idx", 32'(share_idx), 32'd0);
    chk_eq("rst_acc", 32'(stage_acc), 32'd0);
    #13 rst_n = 1'b1;
    cyc();
    chk_eq("rst_rdy", 32'(share_ready), 32'd1);

    // First-share load: 0101 -> x, z, xz.
    share_valid = 1'b1; share_in = 4'b0101;
    cyc();
    share_valid = 1'b0;
    chk_eq("load_acc", 32'(stage_acc), 32'h0025);
    chk_eq("load_idx", 32'(share_idx), 32'd1);
    chk_eq("load_busy", 32'(busy), 32'd1);
    // Stall five cycles at idx=1, then finish: 0101^0011^1010 = 1100 -> z,w,zw.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_eq("stall_acc", 32'(stage_acc), 32'h0025);
      chk_eq("stall_idx", 32'(share_idx), 32'd1);
      chk_eq("stall_rdy", 32'(share_ready), 32'd1);
    end
    share_valid = 1'b1; share_in = 4'b0011;
    cyc();
    share_in = 4'b1010;
    chk_eq("stall_ov_early", 32'(out_valid), 32'd0);
    cyc();
    chk_eq("stall_ov", 32'(out_valid), 32'd1);
    chk_eq("stall_vec", 32'(out_vec), 32'h020C);

    // DONE backpressure with a share offered; it must not be absorbed.
    share_in = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_eq("hold_vec", 32'(out_vec), 32'h020C);
      chk_eq("hold_ov", 32'(out_valid), 32'd1);
      chk_eq("hold_rdy", 32'(share_ready), 32'd0);
    end
    share_valid = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk_eq("hs_busy", 32'(busy), 32'd0);
    chk_eq("hs_ov", 32'(out_valid), 32'd0);
    chk_eq("hs_acc", 32'(stage_acc), 32'h020C);
    chk_eq("hs_rdy", 32'(share_ready), 32'd1);

    run_op(4'b1111, 4'b0000, 4'b0000, 15'h7FFF, "ones");
    // Intermediate acc holds the true product vector of 1011^0110 = 1101.
    share_valid = 1'b1; share_in = 4'b1011;
    cyc();
    share_in = 4'b0110;
    cyc();
    chk_eq("mid_acc", 32'(stage_acc), 32'h126D);
    share_in = 4'b1100;
    cyc();
    share_valid = 1'b0;
    chk_eq("mask_ov", 32'(out_valid), 32'd1);
    chk_eq("mask_vec", 32'(out_vec), 32'h0001);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // Flush beats a valid share at idx=2.
    share_valid = 1'b1; share_in = 4'b0111;
    cyc();
    cyc();
    chk_eq("fl_idx2", 32'(share_idx), 32'd2);
    flush = 1'b1;
    #1;
    chk_eq("fl_rdy", 32'(share_ready), 32'd0);
    cyc();
    flush = 1'b0; share_valid = 1'b0;
    chk_eq("fl_busy", 32'(busy), 32'd0);
    chk_eq("fl_acc", 32'(stage_acc), 32'd0);
    chk_eq("fl_idx", 32'(share_idx), 32'd0);
    cyc();
    chk_eq("fl_ov", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-ACCUM, then a clean operation.
    share_valid = 1'b1; share_in = 4'b1111;
    cyc();
    share_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_busy", 32'(busy), 32'd0);
    chk_eq("arst_acc", 32'(stage_acc), 32'd0);
    chk_eq("arst_idx", 32'(share_idx), 32'd0);
    #2 rst_n = 1'b1;
    cyc();
    chk_eq("arst_ov", 32'(out_valid), 32'd0);
    run_op(4'b0101, 4'b0011, 4'b1010, 15'h020C, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
